uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 tb/tb_uart_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding a single UART transmitter from
// two requesters, a byte source (register-file read path) and a wide source
// (ALU result path). A granted transfer is captured into a shift buffer and
// sent one DATA_WIDTH byte at a time, LSB byte first, handshaking with the
// transmitter's busy flag. A wide word is never interleaved with other bytes.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   rf_valid/data   byte requester; rf_ack pulses when rf_data is captured
//   wd_valid/data   wide requester; wd_ack pulses when wd_data is captured
//   tx_busy         busy flag from the UART transmitter
//   tx_p_data       byte presented to the transmitter (held between loads)
//   tx_data_valid   one-cycle load strobe to the transmitter
//   sched_busy      high whenever the scheduler is not idle
module uart_tx_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDE_BYTES = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             rf_valid,
  input  logic [DATA_WIDTH-1:0]            rf_data,
  output logic                             rf_ack,
  input  logic                             wd_valid,
  input  logic [DATA_WIDTH*WIDE_BYTES-1:0] wd_data,
  output logic                             wd_ack,
  input  logic                             tx_busy,
  output logic [DATA_WIDTH-1:0]            tx_p_data,
  output logic                             tx_data_valid,
  output logic                             sched_busy
);

  localparam int unsigned BUF_W = DATA_WIDTH * WIDE_BYTES;
  localparam int unsigned CNT_W = $clog2(WIDE_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUF_W-1:0]       shift_q, shift_d;
  logic                   last_wide_q, last_wide_d;
  logic                   rf_ack_q, rf_ack_d;
  logic                   wd_ack_q, wd_ack_d;
  logic                   dv_q, dv_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic                   busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      last_wide_q <= 1'b1;
      rf_ack_q    <= 1'b0;
      wd_ack_q    <= 1'b0;
      dv_q        <= 1'b0;
      p_data_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      last_wide_q <= last_wide_d;
      rf_ack_q    <= rf_ack_d;
      wd_ack_q    <= wd_ack_d;
      dv_q        <= dv_d;
      p_data_q    <= p_data_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, arbitration and datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    last_wide_d = last_wide_q;
    rf_ack_d    = 1'b0;
    wd_ack_d    = 1'b0;
    dv_d        = 1'b0;
    p_data_d    = p_data_q;

    unique case (state_q)
      IDLE: begin
        // Byte requester wins when alone, or on a tie if wide went last
        if (rf_valid && (!wd_valid || last_wide_q)) begin
          rf_ack_d    = 1'b1;
          shift_d     = BUF_W'(rf_data);
          cnt_d       = CNT_W'(1);
          last_wide_d = 1'b0;
          state_d     = SEND;
        end else if (wd_valid) begin
          wd_ack_d    = 1'b1;
          shift_d     = wd_data;
          cnt_d       = CNT_W'(WIDE_BYTES);
          last_wide_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          p_data_d = shift_q[DATA_WIDTH-1:0];
          dv_d     = 1'b1;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // Frame done: retire the byte and move to the next one, if any
        if (!tx_busy) begin
          cnt_d   = cnt_q - CNT_W'(1);
          shift_d = shift_q >> DATA_WIDTH;
          state_d = (cnt_q == CNT_W'(1)) ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rf_ack        = rf_ack_q;
  assign wd_ack        = wd_ack_q;
  assign tx_data_valid = dv_q;
  assign tx_p_data     = p_data_q;
  assign sched_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed vector table plus randomized run against a
// transaction-level model (expected-byte queue, round-robin tracker,
// simple transmitter model).
module tb_uart_tx_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned WB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rf_valid, wd_valid, tx_busy;
  logic [DW-1:0] rf_data;
  logic [DW*WB-1:0] wd_data;
  logic          rf_ack, wd_ack, tx_dv, sched_busy;
  logic [DW-1:0] tx_p;

  uart_tx_sched #(.DATA_WIDTH(DW), .WIDE_BYTES(WB)) dut (
    .CLK          (clk),
    .RST          (rst),
    .rf_valid     (rf_valid),
    .rf_data      (rf_data),
    .rf_ack       (rf_ack),
    .wd_valid     (wd_valid),
    .wd_data      (wd_data),
    .wd_ack       (wd_ack),
    .tx_busy      (tx_busy),
    .tx_p_data    (tx_p),
    .tx_data_valid(tx_dv),
    .sched_busy   (sched_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          rv;
    logic [DW-1:0] rd;
    logic          wv;
    logic [DW*WB-1:0] wdat;
    logic          busy;
    int            rep;
    logic          e_ra;
    logic          e_wa;
    logic          e_dv;
    logic [DW-1:0] e_p;
    logic          e_sb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rv, input logic [7:0] rd,
                     input logic wv, input logic [15:0] wdat, input logic busy,
                     input int rep, input logic ra, input logic wa, input logic dv,
                     input logic [7:0] p, input logic sb);
    vec_t v;
    v.rst = r; v.rv = rv; v.rd = rd; v.wv = wv; v.wdat = wdat; v.busy = busy;
    v.rep = rep; v.e_ra = ra; v.e_wa = wa; v.e_dv = dv; v.e_p = p; v.e_sb = sb;
    tbl.push_back(v);
  endtask

  // ---------------- random-phase model state ----------------
  logic [DW-1:0] exp_q[$];
  logic          last_wide;
  logic          prev_dv;
  logic [DW-1:0] last_p;
  logic          tx_active;
  int            tx_phase;
  int            tx_cnt;
  int            rf_wait, wd_wait;
  logic          stop_req;

  // Compare DUT outputs after an edge against the model
  task automatic mon();
    logic          rv_e, wv_e, busy_e;
    logic [DW-1:0] exp_b;
    rv_e = rf_valid; wv_e = wd_valid; busy_e = tx_busy;
    check("ack_exclusive", 32'(rf_ack & wd_ack), 32'd0);
    check("strobe_consecutive", 32'(tx_dv & prev_dv), 32'd0);
    if (rf_ack) begin
      check("rf_ack_without_valid", 32'(rv_e), 32'd1);
      check("rf_ack_mid_transfer", 32'(exp_q.size()), 32'd0);
      if (wv_e) check("rr_tie_rf", 32'(last_wide), 32'd1);
      exp_q.push_back(rf_data);
      last_wide = 1'b0;
      rf_valid  = 1'b0;
      rf_wait   = 0;
    end else if (rv_e) begin
      rf_wait++;
    end
    if (wd_ack) begin
      check("wd_ack_without_valid", 32'(wv_e), 32'd1);
      check("wd_ack_mid_transfer", 32'(exp_q.size()), 32'd0);
      if (rv_e) check("rr_tie_wd", 32'(last_wide), 32'd0);
      for (int i = 0; i < int'(WB); i++) exp_q.push_back(wd_data[i*DW +: DW]);
      last_wide = 1'b1;
      wd_valid  = 1'b0;
      wd_wait   = 0;
    end else if (wv_e) begin
      wd_wait++;
    end
    if (tx_dv) begin
      check("strobe_while_busy", 32'(busy_e), 32'd0);
      check("strobe_before_frame_end", 32'(tx_active), 32'd0);
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check("frame_data", 32'(tx_p), 32'(exp_b));
      last_p = exp_b;
    end else begin
      check("p_data_hold", 32'(tx_p), 32'(last_p));
    end
    prev_dv = tx_dv;
    if (rf_wait > 200) begin
      check("rf_request_starved", 32'(rf_wait), 32'd0);
      rf_wait = 0;
    end
    if (wd_wait > 200) begin
      check("wd_request_starved", 32'(wd_wait), 32'd0);
      wd_wait = 0;
    end
  endtask

  // Transmitter and requester behaviour for the next edge
  task automatic drive();
    if (tx_dv) begin
      tx_active = 1'b1; tx_phase = 1; tx_busy = 1'b0;
    end else if (tx_phase == 1) begin
      tx_phase = 2; tx_busy = 1'b1; tx_cnt = int'($urandom_range(1, 6));
    end else if (tx_phase == 2) begin
      if (tx_cnt > 1) tx_cnt--;
      else begin
        tx_busy = 1'b0; tx_phase = 0; tx_active = 1'b0;
      end
    end else begin
      tx_busy = ($urandom_range(0, 5) == 0);
    end
    if (!rf_ack) begin
      if (!rf_valid) begin
        if (!stop_req && $urandom_range(0, 3) == 0) begin
          rf_valid = 1'b1; rf_data = DW'($urandom);
        end
      end else if (!stop_req && $urandom_range(0, 39) == 0) begin
        rf_valid = 1'b0; rf_wait = 0;
      end
    end
    if (!wd_ack) begin
      if (!wd_valid) begin
        if (!stop_req && $urandom_range(0, 3) == 0) begin
          wd_valid = 1'b1; wd_data = (DW*WB)'($urandom);
        end
      end else if (!stop_req && $urandom_range(0, 39) == 0) begin
        wd_valid = 1'b0; wd_wait = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t, required finish before 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rf_valid = 1'b0; wd_valid = 1'b0; tx_busy = 1'b0;
    rf_data = '0; wd_data = '0;

    //  rst rv rd     wv wdat      busy rep  ra wa dv p      sb
    // reset
    add(1, 0, 8'h00, 0, 16'h0000, 0, 2,   0, 0, 0, 8'h00, 0);
    // byte 0xA5, busy rises one cycle after strobe, held 10 cycles
    add(0, 1, 8'hA5, 0, 16'h0000, 0, 1,   1, 0, 0, 8'h00, 1);
    add(0, 0, 8'hA5, 0, 16'h0000, 0, 1,   0, 0, 1, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 10,  0, 0, 0, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'hA5, 0);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 2,   0, 0, 0, 8'hA5, 0);
    // wide 0x1234: 0x34 then 0x12, second strobe only after busy falls
    add(0, 0, 8'h00, 1, 16'h1234, 0, 1,   0, 1, 0, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 16'h1234, 0, 1,   0, 0, 1, 8'h34, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h34, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 3,   0, 0, 0, 8'h34, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h34, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 1, 8'h12, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h12, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 2,   0, 0, 0, 8'h12, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h12, 0);
    // simultaneous after reset: byte first, then wide wins the next tie
    add(1, 1, 8'h11, 1, 16'hBEEF, 0, 1,   0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h11, 1, 16'hBEEF, 0, 1,   1, 0, 0, 8'h00, 1);
    add(0, 0, 8'h11, 1, 16'hBEEF, 0, 1,   0, 0, 1, 8'h11, 1);
    add(0, 0, 8'h00, 1, 16'hBEEF, 1, 1,   0, 0, 0, 8'h11, 1);
    add(0, 0, 8'h00, 1, 16'hBEEF, 0, 1,   0, 0, 0, 8'h11, 0);
    add(0, 1, 8'h22, 1, 16'hBEEF, 0, 1,   0, 1, 0, 8'h11, 1);
    // transmitter busy at SEND entry: hold with no strobe
    add(0, 1, 8'h22, 0, 16'h0000, 1, 3,   0, 0, 0, 8'h11, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 0, 1,   0, 0, 1, 8'hEF, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 1, 1,   0, 0, 0, 8'hEF, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 0, 1,   0, 0, 0, 8'hEF, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 0, 1,   0, 0, 1, 8'hBE, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 1, 1,   0, 0, 0, 8'hBE, 1);
    add(0, 1, 8'h22, 0, 16'h0000, 0, 1,   0, 0, 0, 8'hBE, 0);
    add(0, 1, 8'h22, 0, 16'h0000, 0, 1,   1, 0, 0, 8'hBE, 1);
    add(0, 0, 8'h22, 0, 16'h0000, 0, 1,   0, 0, 1, 8'h22, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 1,   0, 0, 0, 8'h22, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h22, 0);
    // reset in WAIT_LO after 0x34: no 0x12, pending byte served afterwards
    add(0, 0, 8'h00, 1, 16'h1234, 0, 1,   0, 1, 0, 8'h22, 1);
    add(0, 0, 8'h00, 0, 16'h1234, 0, 1,   0, 0, 1, 8'h34, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 1,   0, 0, 0, 8'h34, 1);
    add(1, 1, 8'h5A, 0, 16'h0000, 1, 1,   0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h5A, 0, 16'h0000, 1, 1,   1, 0, 0, 8'h00, 1);
    add(0, 0, 8'h5A, 0, 16'h0000, 0, 1,   0, 0, 1, 8'h5A, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 1,   0, 0, 0, 8'h5A, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h5A, 0);
    // wide request withdrawn mid-transfer never gets an ack
    add(0, 1, 8'h33, 0, 16'h0000, 0, 1,   1, 0, 0, 8'h5A, 1);
    add(0, 0, 8'h33, 1, 16'hABCD, 0, 1,   0, 0, 1, 8'h33, 1);
    add(0, 0, 8'h00, 1, 16'hABCD, 1, 1,   0, 0, 0, 8'h33, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 1, 1,   0, 0, 0, 8'h33, 1);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 0, 8'h33, 0);
    add(0, 0, 8'h00, 0, 16'h0000, 0, 3,   0, 0, 0, 8'h33, 0);

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        rst = tbl[k].rst; rf_valid = tbl[k].rv; rf_data = tbl[k].rd;
        wd_valid = tbl[k].wv; wd_data = tbl[k].wdat; tx_busy = tbl[k].busy;
        tick();
        check($sformatf("v%0d.%0d rf_ack", k, r), 32'(rf_ack), 32'(tbl[k].e_ra));
        check($sformatf("v%0d.%0d wd_ack", k, r), 32'(wd_ack), 32'(tbl[k].e_wa));
        check($sformatf("v%0d.%0d tx_data_valid", k, r), 32'(tx_dv), 32'(tbl[k].e_dv));
        check($sformatf("v%0d.%0d tx_p_data", k, r), 32'(tx_p), 32'(tbl[k].e_p));
        check($sformatf("v%0d.%0d sched_busy", k, r), 32'(sched_busy), 32'(tbl[k].e_sb));
      end
    end

    // ---------------- randomized run ----------------
    rst = 1'b1; rf_valid = 1'b0; wd_valid = 1'b0; tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    last_wide = 1'b1; prev_dv = 1'b0; last_p = '0;
    tx_active = 1'b0; tx_phase = 0; tx_cnt = 0;
    rf_wait = 0; wd_wait = 0; stop_req = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      drive();
      tick();
      mon();
    end

    // Let outstanding requests and frames complete
    stop_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !rf_valid && !wd_valid && !sched_busy && tx_phase == 0) break;
      drive();
      tick();
      mon();
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_sched_idle", 32'(sched_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
